apb_master: RTL and testbench

APB_MASTER -- requirements
Module: apb_master

---
 rtl/apb_master.sv | 176 +++++++++++++++++
 tb/tb_apb_master.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master.sv
// APB requester: turns one valid/ready command into one APB transfer plus a one-cycle response pulse.
// Optional ACCESS wait-state timeout is built only when APB_MASTER_TIMEOUT_EN is defined.

module apb_master #(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic              pclk,
   input  logic              prstn,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              psel,
   output logic              penable,
   output logic              pwrite,
   output logic [ADDR_W-1:0] paddr,
   output logic [DATA_W-1:0] pwdata,
   input  logic [DATA_W-1:0] prdata,
   input  logic              pready,
   input  logic              pslverr
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } state_t;

   state_t state_r, state_nxt_s;

   logic              cmd_ready_r, cmd_ready_nxt_s;
   logic              psel_r, psel_nxt_s;
   logic              penable_r, penable_nxt_s;
   logic              pwrite_r, pwrite_nxt_s;
   logic [ADDR_W-1:0] paddr_r, paddr_nxt_s;
   logic [DATA_W-1:0] pwdata_r, pwdata_nxt_s;
   logic              rsp_valid_r, rsp_valid_nxt_s;
   logic [DATA_W-1:0] rsp_rdata_r, rsp_rdata_nxt_s;
   logic              rsp_err_r, rsp_err_nxt_s;

   logic accept_s;
   logic done_s;
   logic timeout_s;

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("apb_master: TIMEOUT_CYCLES must be at least 1");
   end

   // cmd_ready_r is low for the first cycle out of reset, so nothing is accepted then.
   assign accept_s = (state_r == ST_IDLE) && cmd_ready_r && cmd_valid;
   assign done_s   = (state_r == ST_ACCESS) && pready;

`ifdef APB_MASTER_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] wait_cnt_r;

   // Stalled-ACCESS cycle counter, restarted for every accepted command.
   always_ff @(posedge pclk or negedge prstn) begin
      if (!prstn) begin
         wait_cnt_r <= {CNT_W{1'b0}};
      end else if (accept_s) begin
         wait_cnt_r <= {CNT_W{1'b0}};
      end else if ((state_r == ST_ACCESS) && !pready) begin
         wait_cnt_r <= wait_cnt_r + CNT_W'(1);
      end else begin
         wait_cnt_r <= wait_cnt_r;
      end
   end

   assign timeout_s = (state_r == ST_ACCESS) && !pready &&
                      (wait_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   assign timeout_s = 1'b0;
`endif

   // State and every output are registered together.
   always_ff @(posedge pclk or negedge prstn) begin
      if (!prstn) begin
         state_r     <= ST_IDLE;
         cmd_ready_r <= 1'b0;
         psel_r      <= 1'b0;
         penable_r   <= 1'b0;
         pwrite_r    <= 1'b0;
         paddr_r     <= {ADDR_W{1'b0}};
         pwdata_r    <= {DATA_W{1'b0}};
         rsp_valid_r <= 1'b0;
         rsp_rdata_r <= {DATA_W{1'b0}};
         rsp_err_r   <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         cmd_ready_r <= cmd_ready_nxt_s;
         psel_r      <= psel_nxt_s;
         penable_r   <= penable_nxt_s;
         pwrite_r    <= pwrite_nxt_s;
         paddr_r     <= paddr_nxt_s;
         pwdata_r    <= pwdata_nxt_s;
         rsp_valid_r <= rsp_valid_nxt_s;
         rsp_rdata_r <= rsp_rdata_nxt_s;
         rsp_err_r   <= rsp_err_nxt_s;
      end
   end

   // Next-state logic: SETUP always lasts one cycle, ACCESS ends on pready or timeout.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               state_nxt_s = ST_SETUP;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_SETUP: begin
            state_nxt_s = ST_ACCESS;
         end
         ST_ACCESS: begin
            if (done_s || timeout_s) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_ACCESS;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Output values for the next cycle, decoded from the next state.
   always_comb begin
      cmd_ready_nxt_s = (state_nxt_s == ST_IDLE);
      psel_nxt_s      = (state_nxt_s != ST_IDLE);
      penable_nxt_s   = (state_nxt_s == ST_ACCESS);
      rsp_valid_nxt_s = done_s || timeout_s;

      if (accept_s) begin
         pwrite_nxt_s = cmd_write;
         paddr_nxt_s  = cmd_addr;
         pwdata_nxt_s = cmd_write ? cmd_wdata : {DATA_W{1'b0}};
      end else begin
         pwrite_nxt_s = pwrite_r;
         paddr_nxt_s  = paddr_r;
         pwdata_nxt_s = pwdata_r;
      end

      if (done_s) begin
         rsp_err_nxt_s   = pslverr;
         rsp_rdata_nxt_s = pwrite_r ? {DATA_W{1'b0}} : prdata;
      end else if (timeout_s) begin
         rsp_err_nxt_s   = 1'b1;
         rsp_rdata_nxt_s = {DATA_W{1'b0}};
      end else begin
         rsp_err_nxt_s   = rsp_err_r;
         rsp_rdata_nxt_s = rsp_rdata_r;
      end
   end

   assign cmd_ready = cmd_ready_r;
   assign psel      = psel_r;
   assign penable   = penable_r;
   assign pwrite    = pwrite_r;
   assign paddr     = paddr_r;
   assign pwdata    = pwdata_r;
   assign rsp_valid = rsp_valid_r;
   assign rsp_rdata = rsp_rdata_r;
   assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_apb_master.sv
// Scoreboard bench for apb_master: a memory-backed APB completer, a reference memory that predicts
// every response at issue time, and an independent monitor that checks each rsp_valid pulse.

module tb_apb_master;

   localparam int TO = 16;

   logic        pclk      = 1'b0;
   logic        prstn     = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_write = 1'b0;
   logic [31:0] cmd_addr  = 32'h0;
   logic [31:0] cmd_wdata = 32'h0;
   logic        cmd_ready;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        psel, penable, pwrite;
   logic [31:0] paddr, pwdata;
   logic [31:0] prdata  = 32'h0;
   logic        pready  = 1'b0;
   logic        pslverr = 1'b0;

   apb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
      .pclk(pclk), .prstn(prstn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
      .prdata(prdata), .pready(pready), .pslverr(pslverr)
   );

   always #5 pclk = ~pclk;

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          waits;
      logic        serr;
      logic [31:0] rdata_exp;
      logic        err_exp;
      int          lat;
      int          acc_cyc;
   } txn_t;

   txn_t        exp_q[$];
   txn_t        plan_q[$];
   logic [31:0] ref_mem   [bit [31:0]];
   logic [31:0] slave_mem [bit [31:0]];

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;
   int slave_mode = 0;

   always @(posedge pclk) cyc <= cyc + 1;

   function automatic logic [31:0] init_val(input logic [31:0] a);
      return (a * 32'd3) ^ 32'hA5A5_0000;
   endfunction

   function automatic logic [31:0] ref_rd(input logic [31:0] a);
      if (ref_mem.exists(a)) return ref_mem[a];
      return init_val(a);
   endfunction

   function automatic logic [31:0] slave_rd(input logic [31:0] a);
      if (slave_mem.exists(a)) return slave_mem[a];
      return init_val(a);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic flag(input string nm);
      n_vec++;
      n_err++;
      $display("FAIL %s: got unexpected event, expected none (cycle %0d)", nm, cyc);
   endtask

   // Presents one command and waits (bounded) for its handshake; the response is predicted here.
   task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input int waits, input logic serr, input logic tmo, output int acc);
      txn_t t;
      int   g;
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_addr  = addr;
      cmd_wdata = wdata;
      g = 0;
      while (cmd_ready !== 1'b1 && g < 100) begin
         @(negedge pclk);
         g++;
      end
      acc = cyc;
      if (cmd_ready !== 1'b1) begin
         flag("cmd_ready_wait_expired");
         cmd_valid = 1'b0;
         return;
      end
      t.wr        = wr;
      t.addr      = addr;
      t.wdata     = wdata;
      t.waits     = waits;
      t.serr      = serr;
      t.acc_cyc   = cyc;
      t.err_exp   = tmo ? 1'b1 : serr;
      t.rdata_exp = (wr || tmo) ? 32'h0 : ref_rd(addr);
      t.lat       = tmo ? (2 + TO) : (3 + waits);
      if (wr && !serr && !tmo) ref_mem[addr] = wdata;
      exp_q.push_back(t);
      plan_q.push_back(t);
      @(negedge pclk);
   endtask

   task automatic drain();
      int g;
      g = 0;
      while (exp_q.size() > 0 && g < 200) begin
         @(negedge pclk);
         g++;
      end
      if (exp_q.size() > 0) flag("response_wait_expired");
   endtask

   task automatic do_reset(input int n);
      prstn = 1'b0;
      exp_q.delete();
      plan_q.delete();
      repeat (n) @(negedge pclk);
      prstn = 1'b1;
   endtask

   // Completer: checks the SETUP/ACCESS address phase and answers from its own memory.
   initial begin : slave
      txn_t cur;
      int   wait_left;
      wait_left = 0;
      forever begin
         @(negedge pclk);
         if (prstn && psel && !penable) begin
            if (plan_q.size() == 0) begin
               flag("setup_without_command");
            end else begin
               cur       = plan_q.pop_front();
               wait_left = cur.waits;
               chk("setup_paddr", paddr, cur.addr);
               chk("setup_pwrite", {31'h0, pwrite}, {31'h0, cur.wr});
               chk("setup_pwdata", pwdata, cur.wr ? cur.wdata : 32'h0);
            end
            pready  = 1'($urandom);
            pslverr = 1'($urandom);
            prdata  = $urandom;
         end else if (prstn && psel && penable) begin
            chk("access_paddr_stable", paddr, cur.addr);
            chk("access_pwdata_stable", pwdata, cur.wr ? cur.wdata : 32'h0);
            chk("access_pwrite_stable", {31'h0, pwrite}, {31'h0, cur.wr});
            if (slave_mode == 1 || wait_left > 0) begin
               if (wait_left > 0) wait_left--;
               pready  = 1'b0;
               pslverr = 1'($urandom);
               prdata  = $urandom;
            end else begin
               pready  = 1'b1;
               pslverr = cur.serr;
               if (pwrite) begin
                  prdata = $urandom;
                  if (!cur.serr) slave_mem[paddr] = pwdata;
               end else begin
                  prdata = slave_rd(paddr);
               end
            end
         end else begin
            pready  = 1'($urandom);
            pslverr = 1'($urandom);
            prdata  = $urandom;
         end
      end
   end

   // Monitor: pops the scoreboard on every response pulse and checks hold behaviour in between.
   initial begin : monitor
      txn_t        e;
      logic [31:0] last_rdata;
      logic        last_err;
      last_rdata = 32'h0;
      last_err   = 1'b0;
      forever begin
         @(negedge pclk);
         if (!prstn) begin
            last_rdata = 32'h0;
            last_err   = 1'b0;
         end else if (rsp_valid) begin
            if (exp_q.size() == 0) begin
               flag("rsp_valid_unexpected");
            end else begin
               e = exp_q.pop_front();
               chk("rsp_rdata", rsp_rdata, e.rdata_exp);
               chk("rsp_err", {31'h0, rsp_err}, {31'h0, e.err_exp});
               chk("rsp_latency", cyc - e.acc_cyc, e.lat);
               chk("rsp_cycle_psel", {31'h0, psel}, 32'h0);
            end
            last_rdata = rsp_rdata;
            last_err   = rsp_err;
         end else begin
            chk("rsp_rdata_hold", rsp_rdata, last_rdata);
            chk("rsp_err_hold", {31'h0, rsp_err}, {31'h0, last_err});
         end
      end
   end

   initial begin : main
      int acc [4];
      int a, g;
      logic [31:0] ra;

      repeat (3) @(negedge pclk);
      chk("reset_psel", {31'h0, psel}, 32'h0);
      chk("reset_penable", {31'h0, penable}, 32'h0);
      chk("reset_pwrite", {31'h0, pwrite}, 32'h0);
      chk("reset_paddr", paddr, 32'h0);
      chk("reset_pwdata", pwdata, 32'h0);
      chk("reset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
      chk("reset_rsp_rdata", rsp_rdata, 32'h0);
      chk("reset_rsp_err", {31'h0, rsp_err}, 32'h0);
      chk("reset_cmd_ready", {31'h0, cmd_ready}, 32'h0);
      prstn = 1'b1;
      @(negedge pclk);
      chk("cmd_ready_after_reset", {31'h0, cmd_ready}, 32'h1);

      // Zero-wait write, then a read of it with two wait states.
      issue(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 1'b0, 1'b0, a);
      cmd_valid = 1'b0;
      drain();
      issue(1'b0, 32'h0000_0010, 32'h0, 2, 1'b0, 1'b0, a);
      cmd_valid = 1'b0;
      drain();

      // Slave error on a read, next command accepted in the response cycle.
      issue(1'b0, 32'h0000_0014, 32'h0, 0, 1'b1, 1'b0, acc[0]);
      issue(1'b1, 32'h0000_0018, 32'h1234_5678, 0, 1'b0, 1'b0, acc[1]);
      cmd_valid = 1'b0;
      chk("err_then_accept_spacing", acc[1] - acc[0], 3);
      drain();

      // Four commands with cmd_valid held high.
      for (int i = 0; i < 4; i++) begin
         issue(1'($urandom), 32'h0000_0100 + 32'(4 * i), $urandom, 0, 1'b0, 1'b0, acc[i]);
      end
      cmd_valid = 1'b0;
      for (int i = 1; i < 4; i++) chk("b2b_spacing", acc[i] - acc[i-1], 3);
      drain();

      // Randomized traffic with wait states, slave errors and idle gaps.
      for (int i = 0; i < 150; i++) begin
         g = $urandom_range(0, 2);
         if (g > 0) begin
            cmd_valid = 1'b0;
            cmd_addr  = $urandom;
            cmd_write = 1'($urandom);
            repeat (g) @(negedge pclk);
         end
         ra = 32'h0000_0100 + 32'(4 * $urandom_range(0, 7));
         issue(1'($urandom), ra, $urandom,
               ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0,
               1'($urandom_range(0, 7) == 0), 1'b0, a);
      end
      cmd_valid = 1'b0;
      drain();

      // Reset while in ACCESS aborts the transfer silently.
      issue(1'b0, 32'h0000_0020, 32'h0, 6, 1'b0, 1'b0, a);
      cmd_valid = 1'b0;
      g = 0;
      while (!(psel && penable) && g < 20) begin
         @(negedge pclk);
         g++;
      end
      chk("reached_access", {31'h0, psel && penable}, 32'h1);
      prstn = 1'b0;
      #1;
      chk("abort_psel", {31'h0, psel}, 32'h0);
      chk("abort_penable", {31'h0, penable}, 32'h0);
      chk("abort_rsp_valid", {31'h0, rsp_valid}, 32'h0);
      chk("abort_cmd_ready", {31'h0, cmd_ready}, 32'h0);
      exp_q.delete();
      plan_q.delete();
      repeat (2) @(negedge pclk);
      prstn = 1'b1;
      @(negedge pclk);
      chk("abort_cmd_ready_release", {31'h0, cmd_ready}, 32'h1);
      repeat (8) @(negedge pclk);

      // Completer never raises pready.
      slave_mode = 1;
`ifdef APB_MASTER_TIMEOUT_EN
      issue(1'b0, 32'h0000_0024, 32'h0, 0, 1'b0, 1'b1, a);
      cmd_valid = 1'b0;
      drain();
      @(negedge pclk);
      chk("timeout_idle_psel", {31'h0, psel}, 32'h0);
      chk("timeout_idle_cmd_ready", {31'h0, cmd_ready}, 32'h1);
`else
      issue(1'b0, 32'h0000_0024, 32'h0, 0, 1'b0, 1'b0, a);
      cmd_valid = 1'b0;
      repeat (100) @(negedge pclk);
      chk("stuck_psel", {31'h0, psel}, 32'h1);
      chk("stuck_penable", {31'h0, penable}, 32'h1);
      chk("stuck_cmd_ready", {31'h0, cmd_ready}, 32'h0);
      do_reset(2);
      @(negedge pclk);
`endif
      slave_mode = 0;

      issue(1'b1, 32'h0000_0104, 32'hCAFE_F00D, 1, 1'b0, 1'b0, a);
      issue(1'b0, 32'h0000_0104, 32'h0, 0, 1'b0, 1'b0, a);
      cmd_valid = 1'b0;
      drain();
      chk("scoreboard_empty", exp_q.size(), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: got no completion, expected end of run before time limit");
      $fatal(1, "simulation time limit reached");
   end

endmodule
